xbar_switch: RTL

- Registered N×N crossbar switch: the successor to the combinational one-hot-select crossbar.
- Each input presents a single-beat transfer with a binary destination index under valid/ready.
- Each output has a round-robin arbiter and a one-entry output register.
- Sits between N producer ports and N consumer ports; contention and backpressure are resolved inside the block rather than by an external one-hot select.

---
 rtl/xbar_switch_pkg.sv | 13 +
 rtl/xbar_rr_arb.sv | 40 ++++
 rtl/xbar_switch.sv | 71 +++++++
 3 files changed

// File: rtl/xbar_switch_pkg.sv
// Shared helpers for the registered crossbar: index-field width and round-robin pointer increment.
package xbar_switch_pkg;

  // Width of a port index field; a 2-port switch still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter for one crossbar output; the pointer moves only when a grant is accepted.
module xbar_rr_arb import xbar_switch_pkg::*; #(
  parameter int N = 4,
  localparam int SW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr;

  // Search starts at ptr and wraps, so the first hit is the fairest requester.
  always_comb begin : search
    int  j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = SW'(j);
        found     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (adv) ptr <= SW'(rr_next(int'(grant_idx), N));
  end

endmodule

// File: rtl/xbar_switch.sv
// Registered NxN crossbar: per-output round-robin arbitration into a one-entry output register.
module xbar_switch import xbar_switch_pkg::*; #(
  parameter int DW = 8,
  parameter int N  = 4,
  localparam int SW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*SW-1:0] in_dest,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic [N-1:0]    out_valid,
  output logic [N*DW-1:0] out_data,
  output logic [N*SW-1:0] out_src,
  input  logic [N-1:0]    out_ready
);

  logic [N-1:0][N-1:0]  req;        // req[o][i]
  logic [N-1:0][N-1:0]  grant;      // grant[o][i]
  logic [N-1:0][SW-1:0] grant_idx;
  logic [N-1:0]         ld_ok;
  logic [N-1:0]         adv;

  // Out-of-range destinations match no output, so they are simply never granted.
  always_comb begin
    req      = '0;
    in_ready = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++)
        req[o][i] = in_valid[i] && (in_dest[i*SW +: SW] == SW'(o));
      ld_ok[o] = !out_valid[o] || out_ready[o];
      adv[o]   = ld_ok[o] && (|req[o]);
    end
    // A grant on output o implies in_dest[i] == o, so OR-ing over outputs is exact.
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++)
        if (ld_ok[o] && grant[o][i]) in_ready[i] = 1'b1;
  end

  for (genvar o = 0; o < N; o++) begin : g_arb
    xbar_rr_arb #(.N(N)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req[o]),
      .adv       (adv[o]),
      .grant     (grant[o]),
      .grant_idx (grant_idx[o])
    );
  end

  // Loading whenever ld_ok covers push, pop-and-push and pop-to-empty in one rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        if (ld_ok[o]) begin
          out_valid[o] <= |grant[o];
          if (|grant[o]) begin
            out_data[o*DW +: DW] <= in_data[int'(grant_idx[o])*DW +: DW];
            out_src[o*SW +: SW]  <= grant_idx[o];
          end
        end
      end
    end
  end

endmodule
